axi_rt_budget_tracker: RTL and testbench
========================================

Name: axi_rt_budget_tracker

Overview:
Per-region read/write bandwidth bookkeeping stage that sits directly downstream of the RT unit's bandwidth probes and address decoders. Consumes the per-handshake byte count, the handshake strobe and the decoded region index for one direction (AW or AR). Maintains a byte budget and a period countdown per region and drives a per-region isolate request back to the RT unit's isolation logic. One instance is used per direction.

Parameters:
NumRegions, 2, number of tracked address regions (>=1)
PeriodWidth, 32, width of period counters in cycles
BudgetWidth, 32, width of budget counters in bytes
BytesWidth, 12, width of per-transfer byte count (LenWidth+SizeWidth+1)
RegionIdxWidth, idx_width(NumRegions), width of region index

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
enable_i  in  1  bookkeeping enable
abort_i  in  1  force period restart in all regions
bytes_i  in  BytesWidth  bytes of the current Ax handshake
happening_i  in  1  Ax valid&ready this cycle
region_i  in  RegionIdxWidth  decoded region of current Ax
budget_i  in  NumRegions*BudgetWidth  configured budget per region
period_i  in  NumRegions*PeriodWidth  configured period per region
budget_left_o  out  NumRegions*BudgetWidth  remaining budget
period_left_o  out  NumRegions*PeriodWidth  remaining period cycles
isolate_o  out  NumRegions  budget exhausted, request isolation
overrun_o  out  NumRegions  sticky: a transfer exceeded remaining budget

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset: all regions to IDLE; budget_left_o=0, period_left_o=0, isolate_o=0, overrun_o=0.
- Per-region FSM, states IDLE, ACTIVE.
- IDLE: outputs 0. enable_i=1 -> next cycle ACTIVE with budget_left=budget_i[r], period_left=period_i[r].
- ACTIVE: enable_i=0 -> next cycle IDLE, all region outputs 0 (overrun cleared).
- ACTIVE, period expiry (period_left==0) or abort_i=1: reload budget_left=budget_i[r], period_left=period_i[r], clear overrun. Config is sampled only at load/reload; mid-period config changes take effect at next reload.
- ACTIVE otherwise: period_left decrements by 1 each cycle.
- Charge: happening_i=1 and region_i==r and ACTIVE -> budget_left = max(budget_left - bytes_i, 0), zero-extended arithmetic, saturating at 0. If bytes_i > budget_left: set overrun[r].
- Simultaneous reload and charge in same cycle: reload value is charged (budget_left = sat(budget_i[r] - bytes_i)); overrun evaluated against budget_i[r]; charge belongs to the new period.
- Charge in IDLE or in the enable cycle from IDLE: ignored.
- region_i >= NumRegions: charge ignored, no region affected.
- isolate_o[r] = ACTIVE & (budget_left==0), purely from registered state; asserts the cycle after the exhausting handshake and deasserts the cycle after reload.
- period_i[r]==0: region reloads every cycle (period of one cycle).
- budget_i[r]==0: isolate_o[r] high from the first ACTIVE cycle.
- Reset asserted mid-period: next cycle every region is in IDLE with all outputs 0, regardless of enable_i.

Decomposition:
- axi_rt_pkg gets budget_t/period_t/ax_bytes_t typedefs and a BytesWidth constant derived from axi_pkg::LenWidth and axi_pkg::SizeWidth.
- Sub-module axi_rt_budget_region: one region FSM plus counters, with charge_i = happening_i & (region_i==r). The top level is a generate loop plus index decoding.

Test Plan:
- Reset then enable, budget_i[0]=64, period_i[0]=10 -> cycle+1: budget_left_o[0]=64, period_left_o[0]=10; counts down to 0, reload at the following cycle to 10.
- Two charges of 32 bytes to region 0 in consecutive cycles, budget 64 -> budget_left 32, then 0; isolate_o[0]=1 the cycle after the second charge; overrun_o[0]=0; region 1 unaffected.
- Charge 48 bytes with budget_left=16 -> budget_left=0, isolate_o=1, overrun_o=1; on period reload both clear and budget_left=budget_i.
- Charge 8 bytes in the same cycle period_left==0, budget_i=64 -> budget_left=56 next cycle, period_left=period_i.
- abort_i pulse mid-period with budget_left=5, period_left=7 -> next cycle budget_left=budget_i, period_left=period_i in all regions; region_i=NumRegions charge -> no change anywhere.
- rst_i asserted for one cycle while enable_i=1 and isolate_o=1 -> next cycle all outputs 0 in IDLE; the cycle after that, reload from config (ACTIVE).

Source files
------------

// File: rtl/axi_rt_pkg.sv
// Shared types and constants for the RT-unit bandwidth budget tracker.
// Byte-count width follows the AXI burst length and size field widths.
package axi_rt_pkg;

    localparam int unsigned LenWidth       = 32'd8;
    localparam int unsigned SizeWidth      = 32'd3;
    localparam int unsigned BytesWidth     = LenWidth + SizeWidth + 32'd1;
    localparam int unsigned DefBudgetWidth = 32'd32;
    localparam int unsigned DefPeriodWidth = 32'd32;

    typedef logic [DefBudgetWidth-1:0] budget_t;
    typedef logic [DefPeriodWidth-1:0] period_t;
    typedef logic [BytesWidth-1:0]     ax_bytes_t;

    typedef enum logic [0:0] {
        RtIdle   = 1'b0,
        RtActive = 1'b1
    } rt_state_e;

    // Bits needed to index n entries; a single entry still takes one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/axi_rt_budget_region.sv
// One tracked region: IDLE/ACTIVE FSM with byte budget and period countdown.
// All outputs, including isolate, come straight from flops.
module axi_rt_budget_region
    import axi_rt_pkg::*;
#(
    parameter int unsigned PeriodWidth = 32'd32,
    parameter int unsigned BudgetWidth = 32'd32,
    parameter int unsigned BytesWidth  = 32'd12
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic                   abort_i,
    input  logic                   charge_i,
    input  logic [BytesWidth-1:0]  bytes_i,
    input  logic [BudgetWidth-1:0] budget_cfg_i,
    input  logic [PeriodWidth-1:0] period_cfg_i,
    output logic [BudgetWidth-1:0] budget_left_o,
    output logic [PeriodWidth-1:0] period_left_o,
    output logic                   isolate_o,
    output logic                   overrun_o
);

    rt_state_e              state_q, state_d;
    logic [BudgetWidth-1:0] budget_q, budget_d;
    logic [PeriodWidth-1:0] period_q, period_d;
    logic                   overrun_q, overrun_d;
    logic                   isolate_q, isolate_d;

    logic [BudgetWidth-1:0] bytes_ext_s;
    logic [BudgetWidth-1:0] base_budget_s;
    logic                   base_overrun_s;

    // State and counter registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RtIdle;
            budget_q  <= '0;
            period_q  <= '0;
            overrun_q <= 1'b0;
            isolate_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            budget_q  <= budget_d;
            period_q  <= period_d;
            overrun_q <= overrun_d;
            isolate_q <= isolate_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            RtIdle: begin
                if (enable_i) begin
                    state_d = RtActive;
                end else begin
                    state_d = RtIdle;
                end
            end
            RtActive: begin
                if (enable_i) begin
                    state_d = RtActive;
                end else begin
                    state_d = RtIdle;
                end
            end
            default: state_d = RtIdle;
        endcase
    end

    // Counter datapath and registered isolate request
    always_comb begin
        bytes_ext_s    = BudgetWidth'(bytes_i);
        base_budget_s  = budget_q;
        base_overrun_s = overrun_q;
        budget_d       = '0;
        period_d       = '0;
        overrun_d      = 1'b0;
        case (state_q)
            RtIdle: begin
                // Charges during the enable cycle do not count against the first period.
                if (enable_i) begin
                    budget_d = budget_cfg_i;
                    period_d = period_cfg_i;
                end else begin
                    budget_d = '0;
                    period_d = '0;
                end
            end
            RtActive: begin
                if (!enable_i) begin
                    budget_d  = '0;
                    period_d  = '0;
                    overrun_d = 1'b0;
                end else begin
                    // On reload the charge is taken from the fresh budget.
                    if ((period_q == '0) || abort_i) begin
                        base_budget_s  = budget_cfg_i;
                        base_overrun_s = 1'b0;
                        period_d       = period_cfg_i;
                    end else begin
                        base_budget_s  = budget_q;
                        base_overrun_s = overrun_q;
                        period_d       = period_q - PeriodWidth'(1);
                    end
                    if (charge_i) begin
                        if (bytes_ext_s > base_budget_s) begin
                            budget_d  = '0;
                            overrun_d = 1'b1;
                        end else begin
                            budget_d  = base_budget_s - bytes_ext_s;
                            overrun_d = base_overrun_s;
                        end
                    end else begin
                        budget_d  = base_budget_s;
                        overrun_d = base_overrun_s;
                    end
                end
            end
            default: begin
                budget_d  = '0;
                period_d  = '0;
                overrun_d = 1'b0;
            end
        endcase
        isolate_d = (state_d == RtActive) && (budget_d == '0);
    end

    assign budget_left_o = budget_q;
    assign period_left_o = period_q;
    assign isolate_o     = isolate_q;
    assign overrun_o     = overrun_q;

endmodule

// File: rtl/axi_rt_budget_tracker.sv
// Per-region bandwidth budget tracker for one AXI direction (AW or AR).
// Decodes the handshake's region index into per-region charge strobes.
module axi_rt_budget_tracker
    import axi_rt_pkg::*;
#(
    parameter int unsigned NumRegions     = 32'd2,
    parameter int unsigned PeriodWidth    = 32'd32,
    parameter int unsigned BudgetWidth    = 32'd32,
    parameter int unsigned BytesWidth     = axi_rt_pkg::BytesWidth,
    parameter int unsigned RegionIdxWidth = idx_width(NumRegions)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              enable_i,
    input  logic                              abort_i,
    input  logic [BytesWidth-1:0]             bytes_i,
    input  logic                              happening_i,
    input  logic [RegionIdxWidth-1:0]         region_i,
    input  logic [NumRegions*BudgetWidth-1:0] budget_i,
    input  logic [NumRegions*PeriodWidth-1:0] period_i,
    output logic [NumRegions*BudgetWidth-1:0] budget_left_o,
    output logic [NumRegions*PeriodWidth-1:0] period_left_o,
    output logic [NumRegions-1:0]             isolate_o,
    output logic [NumRegions-1:0]             overrun_o
);

    for (genvar r = 0; r < NumRegions; r++) begin : g_region
        logic charge_s;

        // Out-of-range indices match no region, so such handshakes are not charged.
        assign charge_s = happening_i && (region_i == RegionIdxWidth'(r));

        axi_rt_budget_region #(
            .PeriodWidth (PeriodWidth),
            .BudgetWidth (BudgetWidth),
            .BytesWidth  (BytesWidth)
        ) i_region (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .enable_i      (enable_i),
            .abort_i       (abort_i),
            .charge_i      (charge_s),
            .bytes_i       (bytes_i),
            .budget_cfg_i  (budget_i[r*BudgetWidth +: BudgetWidth]),
            .period_cfg_i  (period_i[r*PeriodWidth +: PeriodWidth]),
            .budget_left_o (budget_left_o[r*BudgetWidth +: BudgetWidth]),
            .period_left_o (period_left_o[r*PeriodWidth +: PeriodWidth]),
            .isolate_o     (isolate_o[r]),
            .overrun_o     (overrun_o[r])
        );
    end

endmodule

// File: tb/tb_axi_rt_budget_tracker.sv
// Directed self-checking bench for axi_rt_budget_tracker with three regions,
// so that an out-of-range region index is representable on region_i.
module tb_axi_rt_budget_tracker;
    import axi_rt_pkg::*;

    localparam int unsigned NR = 3;
    localparam int unsigned BW = 32;
    localparam int unsigned PW = 32;
    localparam int unsigned XW = axi_rt_pkg::BytesWidth;
    localparam int unsigned RW = idx_width(NR);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b0;
    logic               abort = 1'b0;
    logic [XW-1:0]      bytes = '0;
    logic               happening = 1'b0;
    logic [RW-1:0]      region = '0;
    logic [NR*BW-1:0]   budget = '0;
    logic [NR*PW-1:0]   period = '0;
    logic [NR*BW-1:0]   budget_left;
    logic [NR*PW-1:0]   period_left;
    logic [NR-1:0]      isolate;
    logic [NR-1:0]      overrun;

    int n_cmp = 0;
    int n_err = 0;

    axi_rt_budget_tracker #(
        .NumRegions  (NR),
        .PeriodWidth (PW),
        .BudgetWidth (BW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .enable_i      (enable),
        .abort_i       (abort),
        .bytes_i       (bytes),
        .happening_i   (happening),
        .region_i      (region),
        .budget_i      (budget),
        .period_i      (period),
        .budget_left_o (budget_left),
        .period_left_o (period_left),
        .isolate_o     (isolate),
        .overrun_o     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [BW-1:0] bl(input int r);
        return budget_left[r*BW +: BW];
    endfunction

    function automatic logic [PW-1:0] pl(input int r);
        return period_left[r*PW +: PW];
    endfunction

    initial begin
        budget[0*BW +: BW] = 32'd64;  period[0*PW +: PW] = 32'd10;
        budget[1*BW +: BW] = 32'd100; period[1*PW +: PW] = 32'd20;
        budget[2*BW +: BW] = 32'd0;   period[2*PW +: PW] = 32'd3;

        step(2);
        check_val("rst_budget",  budget_left, '0);
        check_val("rst_period",  period_left, '0);
        check_val("rst_isolate", isolate, 3'b000);
        check_val("rst_overrun", overrun, 3'b000);

        // Enable: config loaded one cycle later
        rst = 1'b0; enable = 1'b1;
        step(1);
        check_val("load_b0", bl(0), 32'd64);
        check_val("load_p0", pl(0), 32'd10);
        check_val("load_b1", bl(1), 32'd100);
        check_val("load_p1", pl(1), 32'd20);
        check_val("load_iso_zero_budget", isolate, 3'b100);

        // Countdown to zero, then reload
        step(10);
        check_val("count_p0_zero", pl(0), 32'd0);
        step(1);
        check_val("reload_p0", pl(0), 32'd10);

        // Two 32-byte charges to region 0
        happening = 1'b1; region = 2'd0; bytes = 12'd32;
        step(1);
        check_val("chg1_b0", bl(0), 32'd32);
        check_val("chg1_iso", isolate, 3'b100);
        step(1);
        happening = 1'b0;
        check_val("chg2_b0", bl(0), 32'd0);
        check_val("chg2_iso", isolate, 3'b101);
        check_val("chg2_ovr", overrun, 3'b000);
        check_val("chg2_b1_untouched", bl(1), 32'd100);
        check_val("chg2_p0", pl(0), 32'd8);

        // Run out the period; reload clears isolate
        step(9);
        check_val("rl2_b0", bl(0), 32'd64);
        check_val("rl2_p0", pl(0), 32'd10);
        check_val("rl2_iso", isolate, 3'b100);

        // 48 to reach 16 left, then 48 more overruns
        happening = 1'b1; bytes = 12'd48;
        step(1);
        check_val("ovr_pre_b0", bl(0), 32'd16);
        step(1);
        happening = 1'b0;
        check_val("ovr_b0", bl(0), 32'd0);
        check_val("ovr_iso", isolate, 3'b101);
        check_val("ovr_flag", overrun, 3'b001);
        step(8);
        check_val("ovr_hold_p0", pl(0), 32'd0);
        check_val("ovr_hold_flag", overrun, 3'b001);
        step(1);
        check_val("ovr_rl_b0", bl(0), 32'd64);
        check_val("ovr_rl_flag", overrun, 3'b000);
        check_val("ovr_rl_iso", isolate, 3'b100);

        // Charge in the same cycle as period expiry hits the new budget
        step(10);
        check_val("same_pre_p0", pl(0), 32'd0);
        happening = 1'b1; bytes = 12'd8;
        step(1);
        check_val("same_b0", bl(0), 32'd56);
        check_val("same_p0", pl(0), 32'd10);

        // Bring region 0 to budget 5 / period 7, then abort
        bytes = 12'd51;
        step(1);
        happening = 1'b0;
        step(2);
        check_val("abort_pre_b0", bl(0), 32'd5);
        check_val("abort_pre_p0", pl(0), 32'd7);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check_val("abort_b0", bl(0), 32'd64);
        check_val("abort_p0", pl(0), 32'd10);
        check_val("abort_b1", bl(1), 32'd100);
        check_val("abort_p1", pl(1), 32'd20);
        check_val("abort_p2", pl(2), 32'd3);

        // Out-of-range region index charges nobody
        happening = 1'b1; region = 2'd3; bytes = 12'd16;
        step(1);
        check_val("oor_b0", bl(0), 32'd64);
        check_val("oor_b1", bl(1), 32'd100);
        check_val("oor_b2", bl(2), 32'd0);
        region = 2'd1; bytes = 12'd10;
        step(1);
        happening = 1'b0;
        check_val("r1_b1", bl(1), 32'd90);
        check_val("r1_b0", bl(0), 32'd64);

        // Mid-period config change waits for the next reload
        budget[0*BW +: BW] = 32'd40;
        step(1);
        check_val("cfg_hold_b0", bl(0), 32'd64);
        check_val("cfg_hold_p0", pl(0), 32'd7);
        check_val("pre_rst_iso", isolate, 3'b100);

        // Reset mid-period with enable held high
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_val("mrst_budget",  budget_left, '0);
        check_val("mrst_period",  period_left, '0);
        check_val("mrst_isolate", isolate, 3'b000);
        check_val("mrst_overrun", overrun, 3'b000);
        step(1);
        check_val("post_rst_b0", bl(0), 32'd40);
        check_val("post_rst_p0", pl(0), 32'd10);
        check_val("post_rst_iso", isolate, 3'b100);

        // Disable returns everything to zero
        enable = 1'b0;
        step(1);
        check_val("dis_budget",  budget_left, '0);
        check_val("dis_period",  period_left, '0);
        check_val("dis_isolate", isolate, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
